// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Write-port arbiter/sequencer for the 32 x 32 register file. Two writeback
// sources (A: ALU result, B: load return) each feed a one-entry holding
// register through a valid/ready handshake. When both holds are full, a
// round-robin pointer decides which one drives the single registered write
// port. Writes to register 0 are accepted but dropped. A combinational
// pending-write query lets upstream hazard logic see writes not yet committed.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active high
//   a_valid_i    source A has a write        a_ready_o  source A accepted
//   a_addr_i     source A destination        a_data_i   source A data
//   b_*          same as A, for source B
//   wr_addr_o    register file write address (registered)
//   wr_data_o    register file write data (registered)
//   reg_write_o  register file write enable (registered)
//   q_addr_i     hazard query address
//   q_pending_o  a write to q_addr_i is held or in the output stage
//   wr_count_o   number of writes issued, saturating
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              a_valid_i,
  output logic              a_ready_o,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_data_i,
  input  logic              b_valid_i,
  output logic              b_ready_o,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_data_i,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              reg_write_o,
  input  logic [ADDR_W-1:0] q_addr_i,
  output logic              q_pending_o,
  output logic [CNT_W-1:0]  wr_count_o
);

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  // Holding registers
  logic              hold_a_vld_q,  hold_a_vld_d;
  logic [ADDR_W-1:0] hold_a_addr_q, hold_a_addr_d;
  logic [DATA_W-1:0] hold_a_data_q, hold_a_data_d;
  logic              hold_b_vld_q,  hold_b_vld_d;
  logic [ADDR_W-1:0] hold_b_addr_q, hold_b_addr_d;
  logic [DATA_W-1:0] hold_b_data_q, hold_b_data_d;

  // Output stage, arbitration pointer and counter
  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
  logic [DATA_W-1:0] wr_data_q,   wr_data_d;
  logic              rr_q,        rr_d;
  logic [CNT_W-1:0]  wr_count_q,  wr_count_d;

  logic grant_a;
  logic grant_b;
  logic accept_a;
  logic accept_b;

  // Round-robin grant: rr_q=0 favours A, rr_q=1 favours B when both are full.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (hold_a_vld_q && hold_b_vld_q) begin
      if (rr_q) begin
        grant_b = 1'b1;
      end else begin
        grant_a = 1'b1;
      end
    end else if (hold_a_vld_q) begin
      grant_a = 1'b1;
    end else if (hold_b_vld_q) begin
      grant_b = 1'b1;
    end else begin
      grant_a = 1'b0;
      grant_b = 1'b0;
    end
  end

  // A hold can take a new entry when empty or when it drains this edge.
  assign a_ready_o = ~rst_i & (~hold_a_vld_q | grant_a);
  assign b_ready_o = ~rst_i & (~hold_b_vld_q | grant_b);
  assign accept_a  = a_valid_i & a_ready_o;
  assign accept_b  = b_valid_i & b_ready_o;

  // Hold A next state: refill wins over drain; address 0 leaves the hold empty.
  always_comb begin
    hold_a_vld_d  = hold_a_vld_q;
    hold_a_addr_d = hold_a_addr_q;
    hold_a_data_d = hold_a_data_q;
    if (accept_a) begin
      hold_a_vld_d  = (a_addr_i != ADDR_ZERO);
      hold_a_addr_d = a_addr_i;
      hold_a_data_d = a_data_i;
    end else if (grant_a) begin
      hold_a_vld_d  = 1'b0;
    end else begin
      hold_a_vld_d  = hold_a_vld_q;
    end
  end

  // Hold B next state: same rules as hold A.
  always_comb begin
    hold_b_vld_d  = hold_b_vld_q;
    hold_b_addr_d = hold_b_addr_q;
    hold_b_data_d = hold_b_data_q;
    if (accept_b) begin
      hold_b_vld_d  = (b_addr_i != ADDR_ZERO);
      hold_b_addr_d = b_addr_i;
      hold_b_data_d = b_data_i;
    end else if (grant_b) begin
      hold_b_vld_d  = 1'b0;
    end else begin
      hold_b_vld_d  = hold_b_vld_q;
    end
  end

  // Output stage, pointer and counter next state driven by the grant.
  always_comb begin
    reg_write_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rr_d        = rr_q;
    wr_count_d  = wr_count_q;
    if (grant_a) begin
      reg_write_d = 1'b1;
      wr_addr_d   = hold_a_addr_q;
      wr_data_d   = hold_a_data_q;
      rr_d        = 1'b1;
    end else if (grant_b) begin
      reg_write_d = 1'b1;
      wr_addr_d   = hold_b_addr_q;
      wr_data_d   = hold_b_data_q;
      rr_d        = 1'b0;
    end else begin
      reg_write_d = 1'b0;
    end
    if ((grant_a || grant_b) && (wr_count_q != CNT_MAX)) begin
      wr_count_d = wr_count_q + CNT_ONE;
    end else begin
      wr_count_d = wr_count_q;
    end
  end

  // State registers; reset discards every held and in-flight write.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_a_vld_q  <= 1'b0;
      hold_a_addr_q <= {ADDR_W{1'b0}};
      hold_a_data_q <= {DATA_W{1'b0}};
      hold_b_vld_q  <= 1'b0;
      hold_b_addr_q <= {ADDR_W{1'b0}};
      hold_b_data_q <= {DATA_W{1'b0}};
      reg_write_q   <= 1'b0;
      wr_addr_q     <= {ADDR_W{1'b0}};
      wr_data_q     <= {DATA_W{1'b0}};
      rr_q          <= 1'b0;
      wr_count_q    <= {CNT_W{1'b0}};
    end else begin
      hold_a_vld_q  <= hold_a_vld_d;
      hold_a_addr_q <= hold_a_addr_d;
      hold_a_data_q <= hold_a_data_d;
      hold_b_vld_q  <= hold_b_vld_d;
      hold_b_addr_q <= hold_b_addr_d;
      hold_b_data_q <= hold_b_data_d;
      reg_write_q   <= reg_write_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      rr_q          <= rr_d;
      wr_count_q    <= wr_count_d;
    end
  end

  // Pending query covers both holds and the output stage; register 0 never pends.
  always_comb begin
    q_pending_o = 1'b0;
    if (q_addr_i == ADDR_ZERO) begin
      q_pending_o = 1'b0;
    end else begin
      q_pending_o = (hold_a_vld_q && (hold_a_addr_q == q_addr_i)) ||
                    (hold_b_vld_q && (hold_b_addr_q == q_addr_i)) ||
                    (reg_write_q  && (wr_addr_q     == q_addr_i));
    end
  end

  assign reg_write_o = reg_write_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign wr_count_o  = wr_count_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 1'b0;
  logic        b_valid = 1'b0;
  logic [4:0]  a_addr = 5'd0;
  logic [4:0]  b_addr = 5'd0;
  logic [4:0]  q_addr = 5'd0;
  logic [31:0] a_data = 32'd0;
  logic [31:0] b_data = 32'd0;
  logic        a_ready;
  logic        b_ready;
  logic        reg_write;
  logic        q_pending;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [15:0] wr_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.ADDR_W(5), .DATA_W(32), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .a_valid_i(a_valid), .a_ready_o(a_ready), .a_addr_i(a_addr), .a_data_i(a_data),
    .b_valid_i(b_valid), .b_ready_o(b_ready), .b_addr_i(b_addr), .b_data_i(b_data),
    .wr_addr_o(wr_addr), .wr_data_o(wr_data), .reg_write_o(reg_write),
    .q_addr_i(q_addr), .q_pending_o(q_pending), .wr_count_o(wr_count)
  );

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        vld;
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  ent_t        m_hold [2];
  logic        m_out_vld;
  logic [4:0]  m_out_addr;
  logic [31:0] m_out_data;
  int          m_last;    // source that won most recently (1 after reset: A preferred)
  int          m_count;
  logic [31:0] m_rf [32];
  logic [31:0] d_rf [32]; // register file as driven by the DUT
  bit          rf_init = 1'b0;
  logic        s_we;
  logic [4:0]  s_addr;
  logic [31:0] s_data;

  function automatic int m_winner();
    if (m_hold[0].vld && m_hold[1].vld) return (m_last == 0) ? 1 : 0;
    if (m_hold[0].vld) return 0;
    if (m_hold[1].vld) return 1;
    return -1;
  endfunction

  function automatic logic m_ready(int s);
    return !rst && (!m_hold[s].vld || (m_winner() == s));
  endfunction

  function automatic logic m_pend(logic [4:0] q);
    if (q == 5'd0) return 1'b0;
    return (m_hold[0].vld && m_hold[0].addr == q) ||
           (m_hold[1].vld && m_hold[1].addr == q) ||
           (m_out_vld && m_out_addr == q);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    int   w;
    logic acc [2];
    logic v [2];
    logic [4:0]  ad [2];
    logic [31:0] dt [2];
    if (!rf_init) begin
      for (int i = 0; i < 32; i++) begin
        m_rf[i] = 32'd0;
        d_rf[i] = 32'd0;
      end
      rf_init = 1'b1;
    end
    if (rst) begin
      m_hold[0]  = '0;
      m_hold[1]  = '0;
      m_out_vld  = 1'b0;
      m_out_addr = 5'd0;
      m_out_data = 32'd0;
      m_last     = 1;
      m_count    = 0;
    end else begin
      if (s_we) d_rf[s_addr] = s_data;
      if (m_out_vld) m_rf[m_out_addr] = m_out_data;
      v[0] = a_valid; ad[0] = a_addr; dt[0] = a_data;
      v[1] = b_valid; ad[1] = b_addr; dt[1] = b_data;
      w = m_winner();
      for (int s = 0; s < 2; s++) acc[s] = v[s] && m_ready(s);
      if (w >= 0) begin
        m_out_vld  = 1'b1;
        m_out_addr = m_hold[w].addr;
        m_out_data = m_hold[w].data;
        m_last     = w;
        if (m_count < 65535) m_count++;
        m_hold[w].vld = 1'b0;
      end else begin
        m_out_vld = 1'b0;
      end
      for (int s = 0; s < 2; s++) begin
        if (acc[s]) begin
          m_hold[s].vld  = (ad[s] != 5'd0);
          m_hold[s].addr = ad[s];
          m_hold[s].data = dt[s];
        end
      end
    end
  end

  // Per-cycle compare of every output against the model
  always @(negedge clk) begin
    s_we   <= reg_write;
    s_addr <= wr_addr;
    s_data <= wr_data;
    chk("a_ready",   64'(a_ready),   64'(m_ready(0)));
    chk("b_ready",   64'(b_ready),   64'(m_ready(1)));
    chk("reg_write", 64'(reg_write), 64'(m_out_vld));
    chk("wr_addr",   64'(wr_addr),   64'(m_out_addr));
    chk("wr_data",   64'(wr_data),   64'(m_out_data));
    chk("wr_count",  64'(wr_count),  64'(m_count));
    chk("q_pending", 64'(q_pending), 64'(m_pend(q_addr)));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_valid = 1'b0;
    b_valid = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ia, ib, idx, run, maxrun;
    logic acc_a, acc_b;
    logic [31:0] expd;

    // Reset state and single A write
    tick();
    chk("rst_a_ready", 64'(a_ready), 64'd0);
    chk("rst_b_ready", 64'(b_ready), 64'd0);
    chk("rst_reg_write", 64'(reg_write), 64'd0);
    chk("rst_wr_count", 64'(wr_count), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    rst = 1'b0;
    #2;
    chk("rel_a_ready", 64'(a_ready), 64'd1);
    chk("rel_b_ready", 64'(b_ready), 64'd1);
    a_addr = 5'd5; a_data = 32'hDEADBEEF; a_valid = 1'b1; q_addr = 5'd5;
    tick();
    a_valid = 1'b0;
    chk("t1_pend_hold", 64'(q_pending), 64'd1);
    chk("t1_rw_early", 64'(reg_write), 64'd0);
    tick();
    chk("t1_rw", 64'(reg_write), 64'd1);
    chk("t1_addr", 64'(wr_addr), 64'd5);
    chk("t1_data", 64'(wr_data), 64'hDEADBEEF);
    chk("t1_count", 64'(wr_count), 64'd1);
    chk("t1_pend_out", 64'(q_pending), 64'd1);
    tick();
    chk("t1_rw_done", 64'(reg_write), 64'd0);
    chk("t1_pend_done", 64'(q_pending), 64'd0);

    // Contested A/B with rr=0
    do_reset();
    a_addr = 5'd3; a_data = 32'h11; b_addr = 5'd4; b_data = 32'h22;
    a_valid = 1'b1; b_valid = 1'b1;
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    chk("t2_b_ready_low", 64'(b_ready), 64'd0);
    chk("t2_a_ready", 64'(a_ready), 64'd1);
    tick();
    chk("t2_first_addr", 64'(wr_addr), 64'd3);
    chk("t2_first_data", 64'(wr_data), 64'h11);
    chk("t2_b_ready_back", 64'(b_ready), 64'd1);
    tick();
    chk("t2_second_addr", 64'(wr_addr), 64'd4);
    chk("t2_second_data", 64'(wr_data), 64'h22);
    chk("t2_count", 64'(wr_count), 64'd2);
    tick();
    chk("t2_idle", 64'(reg_write), 64'd0);

    // Write to register 0 is consumed and dropped
    a_addr = 5'd0; a_data = 32'h1234; a_valid = 1'b1; q_addr = 5'd0;
    #1;
    chk("t4_a_ready", 64'(a_ready), 64'd1);
    chk("t4_pend0", 64'(q_pending), 64'd0);
    tick();
    a_valid = 1'b0;
    chk("t4_pend0_after", 64'(q_pending), 64'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t4_no_write", 64'(reg_write), 64'd0);
    end
    chk("t4_count", 64'(wr_count), 64'd2);

    // Make B the favoured source, then collide on register 7
    a_addr = 5'd9; a_data = 32'h99; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    repeat (2) tick();
    a_addr = 5'd7; a_data = 32'hAA; b_addr = 5'd7; b_data = 32'hBB;
    a_valid = 1'b1; b_valid = 1'b1;
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    chk("t5_first_b", 64'(wr_data), 64'hBB);
    tick();
    chk("t5_second_a", 64'(wr_data), 64'hAA);
    tick();
    chk("t5_rf7_dut", 64'(d_rf[7]), 64'hAA);
    chk("t5_rf7_model", 64'(m_rf[7]), 64'hAA);

    // Dual streaming of 8 writes each
    do_reset();
    ia = 0; ib = 0; idx = 0; run = 0; maxrun = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      a_valid = (ia < 8); a_addr = 5'(ia + 1);  a_data = 32'hA000_0000 + 32'(ia);
      b_valid = (ib < 8); b_addr = 5'(ib + 10); b_data = 32'hB000_0000 + 32'(ib);
      @(negedge clk);
      acc_a = a_valid && a_ready;
      acc_b = b_valid && b_ready;
      tick();
      if (acc_a) ia++;
      if (acc_b) ib++;
      if (reg_write) begin
        expd = ((idx % 2) == 0) ? 32'hA000_0000 + 32'(idx / 2) : 32'hB000_0000 + 32'(idx / 2);
        chk("t3_order", 64'(wr_data), 64'(expd));
        idx++;
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
    end
    a_valid = 1'b0; b_valid = 1'b0;
    chk("t3_total", 64'(idx), 64'd16);
    chk("t3_run", 64'(maxrun), 64'd16);
    chk("t3_count", 64'(wr_count), 64'd16);

    // Reset with both holds full and a write in flight
    a_addr = 5'd12; a_data = 32'hC1; b_addr = 5'd13; b_data = 32'hD1;
    a_valid = 1'b1; b_valid = 1'b1;
    tick();
    a_addr = 5'd14; a_data = 32'hC2;
    tick();
    chk("t6_rw_before", 64'(reg_write), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("t6_rw_rst", 64'(reg_write), 64'd0);
    chk("t6_a_ready_rst", 64'(a_ready), 64'd0);
    chk("t6_b_ready_rst", 64'(b_ready), 64'd0);
    chk("t6_count_rst", 64'(wr_count), 64'd0);
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_no_stale", 64'(reg_write), 64'd0);
    end
    chk("t6_count_after", 64'(wr_count), 64'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      a_valid = ($urandom_range(0, 3) != 0);
      b_valid = ($urandom_range(0, 3) != 0);
      a_addr  = 5'($urandom_range(0, 7));
      b_addr  = 5'($urandom_range(0, 7));
      a_data  = $urandom;
      b_data  = $urandom;
      q_addr  = 5'($urandom_range(0, 7));
      tick();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 32; i++) chk("rf_final", 64'(d_rf[i]), 64'(m_rf[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter and sequencer for the 32 x 32 register file. Two writeback sources (A: ALU result path, B: load/memory return path) share the register file's single write port. Each source gets a one-entry holding register with a valid/ready handshake, and contested cycles are resolved by round-robin. Writes to register 0 are discarded, and a combinational pending-write query is provided for hazard detection upstream.

## Interface
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- CNT_W, 16, width of the committed-write counter

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous reset, active-high
- a_valid  input  1  source A has a write
- a_ready  output  1  source A entry accepted this edge when a_valid&a_ready
- a_addr  input  ADDR_W  source A destination register
- a_data  input  DATA_W  source A write data
- b_valid, b_ready, b_addr, b_data: same as A, for source B
- wr_addr  output  ADDR_W  to register file write address (registered)
- wr_data  output  DATA_W  to register file write data (registered)
- reg_write  output  1  to register file RegWrite (registered)
- q_addr  input  ADDR_W  hazard query address
- q_pending  output  1  a write to q_addr is held or in the output stage
- wr_count  output  CNT_W  number of writes issued, saturating

## Operation
- State:
  - hold_a and hold_b, each {vld, addr, data}
  - output stage {reg_write, wr_addr, wr_data}
  - rr pointer: 0 favours A, 1 favours B
  - wr_count
- Acceptance:
  - a_ready = ~rst & (~hold_a.vld | grant_a); B is symmetric.
  - On a_valid&a_ready with a_addr≠0: hold_a loads {1, a_addr, a_data}.
  - On a_valid&a_ready with a_addr=0: the entry is consumed and discarded; hold_a clears if it was granted, otherwise it stays empty.
  - A granted hold can be refilled on the same edge, giving one write per cycle per source when uncontested.
- Arbitration (combinational on hold valids):
  - Only hold_a.vld: grant_a.
  - Only hold_b.vld: grant_b.
  - Both valid: grant_a if rr=0, else grant_b.
  - Neither valid: no grant.
- On a grant:
  - The output stage loads {1, winner addr, winner data}.
  - The winner's hold clears unless refilled.
  - rr is set to the opposite of the winner.
  - wr_count increments, saturating at 2^CNT_W-1.
- With no grant, reg_write=0 next cycle; wr_addr and wr_data hold their last values.
- Same-address writes from A and B are committed in grant order. The later grant wins in the register file. No merging is performed.
- q_pending = (q_addr≠0) & ((hold_a.vld & hold_a.addr==q_addr) | (hold_b.vld & hold_b.addr==q_addr) | (reg_write & wr_addr==q_addr)). It is purely combinational and covers entries on which the register file has not yet completed its write.

## Timing
- Reset values (asynchronous, immediate):
  - hold_a.vld=0, hold_b.vld=0
  - reg_write=0, wr_addr=0, wr_data=0
  - rr=0, wr_count=0
  - a_ready=0 and b_ready=0 while rst is high
- First edge after rst falls: a_ready=1 and b_ready=1.
- Uncontested latency:
  - Accepted at edge k; hold valid during cycle k→k+1.
  - Granted at edge k+1; reg_write=1 during cycle k+1→k+2.
  - Register file commits at edge k+2.
- Contested: the loser waits exactly one extra cycle, and its ready stays low meanwhile. Worst-case wait is 1 cycle because rr alternates.
- Sustained dual-source traffic: aggregate 1 write/cycle; each source gets 1 write per 2 cycles.
- rst asserted mid-operation: all held and in-flight writes are lost, reg_write drops immediately, and no partial write is issued.

## Test plan
- Reset, release, then a single A write addr=5 data=0xDEADBEEF: reg_write=1 with wr_addr=5 and wr_data=0xDEADBEEF exactly 2 cycles after acceptance; wr_count=1; q_pending(5)=1 for those 2 cycles, then 0.
- A and B valid on the same cycle, addr 3 (0x11) and 4 (0x22), rr=0: A issues first, then B the next cycle; b_ready is low for 1 cycle; rr ends at 0.
- Both sources stream 8 writes continuously: output alternates A,B,A,B…; reg_write stays high 16 consecutive cycles; no entry is lost or duplicated; wr_count=16.
- A write to addr 0 data=0x1234: accepted (a_ready=1), never appears on reg_write; wr_count is unchanged; q_pending(0)=0.
- A and B both target addr 7 (A=0xAA, B=0xBB) with rr=1: B is issued first, then A; the register file's final value is 0xAA.
- Assert rst while both holds are full and reg_write=1: reg_write=0 and both readies=0 immediately; after release no stale write is issued and wr_count=0.
